fifomult_arbiter: RTL and testbench
===================================

Name: fifomult_arbiter

Overview:
- Two-requester round-robin arbiter that shares one fifomult2024 multiplier instance.
- Accepts operand pairs with parity bits from requester 0 and requester 1, and issues them one at a time to the multiplier input.
- Records the requester ID of each issued operation in an internal in-order tag FIFO.
- Routes each multiplier result, with its result parity and argument-parity-error flag, back to the requester that issued it.

Parameters:
- DATA_W, 16, operand width; result width is 2*DATA_W.
- TAG_DEPTH, 4, maximum outstanding operations inside the multiplier (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- reqN_valid  in  1  requester N (N=0,1) has an operation.
- reqN_arg_a  in  DATA_W  operand A.
- reqN_arg_a_parity  in  1  even parity of A.
- reqN_arg_b  in  DATA_W  operand B.
- reqN_arg_b_parity  in  1  even parity of B.
- reqN_ready  out  1  operation accepted this cycle.
- mult_in_valid  out  1  operation presented to the multiplier.
- mult_in_ready  in  1  multiplier accepts the presented operation.
- mult_arg_a, mult_arg_b  out  DATA_W  issued operands.
- mult_arg_a_parity, mult_arg_b_parity  out  1  issued parities, passed through unchanged.
- mult_out_valid  in  1  multiplier result valid, in issue order.
- mult_result  in  2*DATA_W  product.
- mult_result_parity  in  1  result parity.
- mult_arg_parity_error  in  1  PARITY_ERR(1)/PARITY_OK(0) for that operation.
- rspN_valid  out  1  response to requester N; one-cycle pulse, no backpressure.
- rspN_result  out  2*DATA_W  product.
- rspN_result_parity  out  1  result parity.
- rspN_parity_error  out  1  argument parity status.
- outstanding  out  $clog2(TAG_DEPTH)+1  operations issued but not yet returned.
- err_spurious  out  1  sticky: result arrived with the tag FIFO empty.

Behaviour:
Reset:
- When rst=1 at a clock edge, all outputs become 0 next cycle: reqN_ready, mult_in_valid, mult_* payload, rspN_*, outstanding, err_spurious.
- Tag FIFO is emptied; the round-robin pointer is set to requester 0 (requester 0 has priority on the first contention).
- Reset mid-operation discards all in-flight tags. The multiplier must be reset at the same time; any result arriving after reset with no tag sets err_spurious.

Issue state machine, states IDLE and ISSUE:
- IDLE: grant is allowed when outstanding < TAG_DEPTH.
  - Candidates are the requesters with reqN_valid=1.
  - With one candidate, that requester wins.
  - With two candidates, the requester the pointer designates wins; the pointer then moves to the other requester.
  - Winner sees reqN_ready=1 combinationally in that cycle; operands and parities are captured into the issue register.
  - Go to ISSUE with mult_in_valid=1 on the next cycle, so accept-to-issue latency is 1 cycle.
- ISSUE:
  - mult_in_valid and the payload are held stable until mult_in_valid & mult_in_ready.
  - No grant is given while in ISSUE (at most one issue per 2 cycles).
  - On the handshake, push the winner ID into the tag FIFO and return to IDLE.
- Outstanding limit: if outstanding == TAG_DEPTH, no grant is given, even if a pop happens in the same cycle.

Return path:
- When mult_out_valid=1, pop the head tag.
- Drive rsp[tag]_valid=1 and rsp[tag]_* from the multiplier on the next cycle (registered, 1-cycle latency). The other requester's rsp_valid stays 0.
- When idle, rspN data outputs hold their last value.
- Push and pop in the same cycle leave outstanding unchanged; it equals pushes minus pops.
- mult_out_valid with an empty FIFO: no rsp pulse, outstanding stays 0, err_spurious=1 until reset.

Parity:
- The arbiter does not check parity. Argument parities pass through unchanged.
- mult_arg_parity_error is forwarded unchanged, so an error result is routed like any other result.

Test Plan:
- Single requester: req0 A=3, B=5, correct parities, no contention → req0_ready 1 cycle; mult_in_valid next cycle with 3/5; result 15 returned → rsp0_valid pulse with 15 one cycle later; rsp1_valid stays 0; outstanding goes 0→1→0.
- Contention: both requesters valid continuously with req0 = 2×2 and req1 = 7×7 → grants alternate 0,1,0,1; responses rsp0=4 and rsp1=49 in issue order.
- Backpressure: mult_in_ready held 0 for 5 cycles → mult_in_valid and payload stable; no reqN_ready during those cycles; issue completes on the cycle ready rises.
- Full: TAG_DEPTH=4, no results returned → exactly 4 issues; 5th request stalls until one mult_out_valid pulse, then is granted; outstanding never exceeds 4.
- Parity error: req1 A=1 with arg_a_parity=0, multiplier flags PARITY_ERR → rsp1_parity_error=1 on rsp1.
- Spurious and reset: mult_out_valid pulse with no outstanding operations → err_spurious=1, no rsp pulse. rst during 2 outstanding → all outputs 0 and outstanding=0 next cycle, err_spurious cleared.

Source files
------------

// File: rtl/fifomult_arbiter.sv
// fifomult_arbiter: shares one fifomult2024 multiplier between two requesters.
//
// The arbiter grants one requester at a time. With two requesters waiting, a round-robin
// pointer picks the winner. The winning operands go into an issue register and are presented
// to the multiplier. Each issued operation pushes its requester ID into an in-order tag FIFO.
// Each multiplier result pops that FIFO and is returned, registered, to the matching requester.
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   reqN_*                      requester N operands/parities in, reqN_ready out (combinational)
//   mult_in_valid/ready         issue handshake to the multiplier, mult_arg_* issued payload
//   mult_out_valid, mult_*      multiplier result stream, in issue order
//   rspN_*                      one-cycle response pulse plus held result data for requester N
//   outstanding                 operations issued but not yet returned
//   err_spurious                sticky, a result arrived while no operation was outstanding
module fifomult_arbiter #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned TAG_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req0_valid,
   input  logic [DATA_W-1:0]          req0_arg_a,
   input  logic                       req0_arg_a_parity,
   input  logic [DATA_W-1:0]          req0_arg_b,
   input  logic                       req0_arg_b_parity,
   output logic                       req0_ready,
   input  logic                       req1_valid,
   input  logic [DATA_W-1:0]          req1_arg_a,
   input  logic                       req1_arg_a_parity,
   input  logic [DATA_W-1:0]          req1_arg_b,
   input  logic                       req1_arg_b_parity,
   output logic                       req1_ready,
   output logic                       mult_in_valid,
   input  logic                       mult_in_ready,
   output logic [DATA_W-1:0]          mult_arg_a,
   output logic                       mult_arg_a_parity,
   output logic [DATA_W-1:0]          mult_arg_b,
   output logic                       mult_arg_b_parity,
   input  logic                       mult_out_valid,
   input  logic [2*DATA_W-1:0]        mult_result,
   input  logic                       mult_result_parity,
   input  logic                       mult_arg_parity_error,
   output logic                       rsp0_valid,
   output logic [2*DATA_W-1:0]        rsp0_result,
   output logic                       rsp0_result_parity,
   output logic                       rsp0_parity_error,
   output logic                       rsp1_valid,
   output logic [2*DATA_W-1:0]        rsp1_result,
   output logic                       rsp1_result_parity,
   output logic                       rsp1_parity_error,
   output logic [$clog2(TAG_DEPTH):0] outstanding,
   output logic                       err_spurious
);

   localparam int unsigned PtrW = $clog2(TAG_DEPTH);
   localparam int unsigned CntTop = TAG_DEPTH;
   localparam logic [PtrW:0] FullCnt = CntTop[PtrW:0];

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e              state_q, state_d;
   logic                rr_q, rr_d;       // requester favoured on the next contention
   logic                grant0, grant1;
   logic                push, pop, spurious;
   logic                head_id;

   logic [DATA_W-1:0]   arg_a_q, arg_b_q;
   logic                par_a_q, par_b_q;
   logic                id_q;

   logic                tag_mem_q [TAG_DEPTH];
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]       count_q, count_d;

   logic                rsp0_valid_q, rsp1_valid_q;
   logic [2*DATA_W-1:0] rsp0_result_q, rsp1_result_q;
   logic                rsp0_rpar_q, rsp1_rpar_q;
   logic                rsp0_perr_q, rsp1_perr_q;
   logic                err_spurious_q;

   // Issue FSM and round-robin grant. The grant uses the registered count, so a pop in the
   // same cycle does not open a slot until the next cycle.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      case (state_q)
         StIdle: begin
            if (count_q != FullCnt) begin
               if (req0_valid && req1_valid) begin
                  grant0 = ~rr_q;
                  grant1 = rr_q;
                  rr_d   = ~rr_q;
               end else begin
                  grant0 = req0_valid;
                  grant1 = req1_valid;
               end
               if (req0_valid || req1_valid) begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            if (mult_in_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign push     = (state_q == StIssue) && mult_in_ready;
   assign pop      = mult_out_valid && (count_q != '0);
   assign spurious = mult_out_valid && (count_q == '0);
   assign head_id  = tag_mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         rr_q           <= 1'b0;
         arg_a_q        <= '0;
         arg_b_q        <= '0;
         par_a_q        <= 1'b0;
         par_b_q        <= 1'b0;
         id_q           <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         rsp0_valid_q   <= 1'b0;
         rsp1_valid_q   <= 1'b0;
         rsp0_result_q  <= '0;
         rsp1_result_q  <= '0;
         rsp0_rpar_q    <= 1'b0;
         rsp1_rpar_q    <= 1'b0;
         rsp0_perr_q    <= 1'b0;
         rsp1_perr_q    <= 1'b0;
         err_spurious_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_q           <= rr_d;
         count_q        <= count_d;
         err_spurious_q <= err_spurious_q | spurious;
         if (grant0 || grant1) begin
            arg_a_q <= grant1 ? req1_arg_a : req0_arg_a;
            arg_b_q <= grant1 ? req1_arg_b : req0_arg_b;
            par_a_q <= grant1 ? req1_arg_a_parity : req0_arg_a_parity;
            par_b_q <= grant1 ? req1_arg_b_parity : req0_arg_b_parity;
            id_q    <= grant1;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         rsp0_valid_q <= pop && !head_id;
         rsp1_valid_q <= pop && head_id;
         if (pop && !head_id) begin
            rsp0_result_q <= mult_result;
            rsp0_rpar_q   <= mult_result_parity;
            rsp0_perr_q   <= mult_arg_parity_error;
         end
         if (pop && head_id) begin
            rsp1_result_q <= mult_result;
            rsp1_rpar_q   <= mult_result_parity;
            rsp1_perr_q   <= mult_arg_parity_error;
         end
      end
   end

   // Tag storage needs no reset: entries are only read between matching push and pop.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         tag_mem_q[wr_ptr_q] <= id_q;
      end
   end

   assign req0_ready         = grant0;
   assign req1_ready         = grant1;
   assign mult_in_valid      = (state_q == StIssue);
   assign mult_arg_a         = arg_a_q;
   assign mult_arg_b         = arg_b_q;
   assign mult_arg_a_parity  = par_a_q;
   assign mult_arg_b_parity  = par_b_q;
   assign rsp0_valid         = rsp0_valid_q;
   assign rsp0_result        = rsp0_result_q;
   assign rsp0_result_parity = rsp0_rpar_q;
   assign rsp0_parity_error  = rsp0_perr_q;
   assign rsp1_valid         = rsp1_valid_q;
   assign rsp1_result        = rsp1_result_q;
   assign rsp1_result_parity = rsp1_rpar_q;
   assign rsp1_parity_error  = rsp1_perr_q;
   assign outstanding        = count_q;
   assign err_spurious       = err_spurious_q;

endmodule

// File: tb/tb_fifomult_arbiter.sv
// Testbench for fifomult_arbiter. Inputs are driven 1 time unit after the rising edge and
// outputs are sampled on the falling edge. The bench plays the multiplier itself.
module tb_fifomult_arbiter;

   localparam int unsigned DW = 16;
   localparam int unsigned TD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_arg_a_parity, req0_arg_b_parity, req0_ready;
   logic [DW-1:0] req0_arg_a, req0_arg_b;
   logic          req1_valid, req1_arg_a_parity, req1_arg_b_parity, req1_ready;
   logic [DW-1:0] req1_arg_a, req1_arg_b;
   logic          mult_in_valid, mult_in_ready, mult_arg_a_parity, mult_arg_b_parity;
   logic [DW-1:0] mult_arg_a, mult_arg_b;
   logic          mult_out_valid, mult_result_parity, mult_arg_parity_error;
   logic [2*DW-1:0] mult_result;
   logic          rsp0_valid, rsp0_result_parity, rsp0_parity_error;
   logic [2*DW-1:0] rsp0_result;
   logic          rsp1_valid, rsp1_result_parity, rsp1_parity_error;
   logic [2*DW-1:0] rsp1_result;
   logic [$clog2(TD):0] outstanding;
   logic          err_spurious;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic          v0, v1;
      logic [DW-1:0] a0, b0, a1, b1;
      logic          er0, er1;
      logic [DW-1:0] ea, eb;
      logic [31:0]   eprod;
   } vec_t;

   typedef struct {
      logic        id;
      logic [31:0] prod;
      logic        rpar;
      logic        perr;
   } res_t;

   fifomult_arbiter #(.DATA_W(DW), .TAG_DEPTH(TD)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_arg_a(req0_arg_a), .req0_arg_a_parity(req0_arg_a_parity),
      .req0_arg_b(req0_arg_b), .req0_arg_b_parity(req0_arg_b_parity), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_arg_a(req1_arg_a), .req1_arg_a_parity(req1_arg_a_parity),
      .req1_arg_b(req1_arg_b), .req1_arg_b_parity(req1_arg_b_parity), .req1_ready(req1_ready),
      .mult_in_valid(mult_in_valid), .mult_in_ready(mult_in_ready),
      .mult_arg_a(mult_arg_a), .mult_arg_a_parity(mult_arg_a_parity),
      .mult_arg_b(mult_arg_b), .mult_arg_b_parity(mult_arg_b_parity),
      .mult_out_valid(mult_out_valid), .mult_result(mult_result),
      .mult_result_parity(mult_result_parity), .mult_arg_parity_error(mult_arg_parity_error),
      .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
      .rsp0_result_parity(rsp0_result_parity), .rsp0_parity_error(rsp0_parity_error),
      .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
      .rsp1_result_parity(rsp1_result_parity), .rsp1_parity_error(rsp1_parity_error),
      .outstanding(outstanding), .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic res_t mk_res(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic pa, input logic pb);
      res_t r;
      r.id   = id;
      r.prod = 32'(a) * 32'(b);
      r.rpar = ^r.prod;
      r.perr = ((^a) != pa) || ((^b) != pb);
      return r;
   endfunction

   task automatic check_reset_zero(input string tag);
      check({tag, "_ready0"}, 64'(req0_ready), 64'(0));
      check({tag, "_ready1"}, 64'(req1_ready), 64'(0));
      check({tag, "_mult_in_valid"}, 64'(mult_in_valid), 64'(0));
      check({tag, "_mult_payload"},
            64'({mult_arg_a, mult_arg_b, mult_arg_a_parity, mult_arg_b_parity}), 64'(0));
      check({tag, "_rsp0"}, 64'({rsp0_valid, rsp0_result, rsp0_result_parity, rsp0_parity_error}),
            64'(0));
      check({tag, "_rsp1"}, 64'({rsp1_valid, rsp1_result, rsp1_result_parity, rsp1_parity_error}),
            64'(0));
      check({tag, "_outstanding"}, 64'(outstanding), 64'(0));
      check({tag, "_err_spurious"}, 64'(err_spurious), 64'(0));
   endtask

   // Returns one multiplier result for a single cycle.
   task automatic return_result(input logic [31:0] prod, input logic perr);
      mult_out_valid        = 1'b1;
      mult_result           = prod;
      mult_result_parity    = ^prod;
      mult_arg_parity_error = perr;
      @(posedge clk); #1;
      mult_out_valid        = 1'b0;
      mult_arg_parity_error = 1'b0;
   endtask

   task automatic set_req0(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
      req0_valid = v; req0_arg_a = a; req0_arg_b = b;
      req0_arg_a_parity = ^a; req0_arg_b_parity = ^b;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t        vecs [10];
      res_t        mq [$];
      res_t        accq [$];
      res_t        cur, prev;
      logic        cur_rv, prev_rv, exp_next, found;
      logic [DW-1:0] ca, cb;
      int          grants, issued, returned;

      vecs[0] = '{1'b1, 1'b0, 16'd3, 16'd5, 16'd0, 16'd0, 1'b1, 1'b0, 16'd3, 16'd5, 32'd15};
      vecs[1] = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd7, 16'd7, 1'b0, 1'b1, 16'd7, 16'd7, 32'd49};
      vecs[2] = '{1'b1, 1'b1, 16'd2, 16'd2, 16'd7, 16'd7, 1'b1, 1'b0, 16'd2, 16'd2, 32'd4};
      vecs[3] = '{1'b1, 1'b1, 16'd2, 16'd2, 16'd7, 16'd7, 1'b0, 1'b1, 16'd7, 16'd7, 32'd49};
      vecs[4] = '{1'b1, 1'b1, 16'd2, 16'd2, 16'd7, 16'd7, 1'b1, 1'b0, 16'd2, 16'd2, 32'd4};
      vecs[5] = '{1'b1, 1'b1, 16'd2, 16'd2, 16'd7, 16'd7, 1'b0, 1'b1, 16'd7, 16'd7, 32'd49};
      vecs[6] = '{1'b1, 1'b0, 16'd6, 16'd9, 16'd0, 16'd0, 1'b1, 1'b0, 16'd6, 16'd9, 32'd54};
      vecs[7] = '{1'b1, 1'b1, 16'd2, 16'd2, 16'd7, 16'd7, 1'b1, 1'b0, 16'd2, 16'd2, 32'd4};
      vecs[8] = '{1'b0, 1'b1, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF,
                  32'hFFFE_0001};
      vecs[9] = '{1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0};

      rst = 1'b1;
      set_req0(1'b0, '0, '0);
      req1_valid = 1'b0; req1_arg_a = '0; req1_arg_b = '0;
      req1_arg_a_parity = 1'b0; req1_arg_b_parity = 1'b0;
      mult_in_ready = 1'b0; mult_out_valid = 1'b0; mult_result = '0;
      mult_result_parity = 1'b0; mult_arg_parity_error = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_zero("reset");
      @(posedge clk); #1;

      // Table: one operation per vector, issued then returned, from idle with nothing in flight.
      for (int i = 0; i < 10; i++) begin
         logic any, id;
         any = vecs[i].er0 | vecs[i].er1;
         id  = vecs[i].er1;
         set_req0(vecs[i].v0, vecs[i].a0, vecs[i].b0);
         req1_valid = vecs[i].v1; req1_arg_a = vecs[i].a1; req1_arg_b = vecs[i].b1;
         req1_arg_a_parity = ^vecs[i].a1; req1_arg_b_parity = ^vecs[i].b1;
         mult_in_ready = 1'b1;
         @(negedge clk);
         check($sformatf("vec%0d_ready0", i), 64'(req0_ready), 64'(vecs[i].er0));
         check($sformatf("vec%0d_ready1", i), 64'(req1_ready), 64'(vecs[i].er1));
         @(posedge clk); #1;
         req0_valid = 1'b0; req1_valid = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_issue_valid", i), 64'(mult_in_valid), 64'(any));
         ca = mult_arg_a; cb = mult_arg_b;
         if (any) begin
            check($sformatf("vec%0d_issue_ab", i), 64'({ca, cb}),
                  64'({vecs[i].ea, vecs[i].eb}));
         end
         @(posedge clk); #1;
         mult_out_valid = any;
         mult_result = 32'(ca) * 32'(cb);
         mult_result_parity = ^(32'(ca) * 32'(cb));
         @(negedge clk);
         check($sformatf("vec%0d_outstanding_issued", i), 64'(outstanding), 64'(any));
         @(posedge clk); #1;
         mult_out_valid = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_rsp0_valid", i), 64'(rsp0_valid), 64'(any & ~id));
         check($sformatf("vec%0d_rsp1_valid", i), 64'(rsp1_valid), 64'(any & id));
         if (any) begin
            check($sformatf("vec%0d_rsp_result", i), 64'(id ? rsp1_result : rsp0_result),
                  64'(vecs[i].eprod));
         end
         check($sformatf("vec%0d_outstanding_done", i), 64'(outstanding), 64'(0));
         @(posedge clk); #1;
      end

      // Backpressure: payload held and no grants while the multiplier stalls.
      set_req0(1'b1, 16'd9, 16'd11);
      mult_in_ready = 1'b0;
      @(negedge clk);
      check("bp_grant", 64'(req0_ready), 64'(1));
      @(posedge clk); #1;
      set_req0(1'b1, 16'h1234, 16'h4321);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(mult_in_valid), 64'(1));
         check("bp_hold_payload", 64'({mult_arg_a, mult_arg_b}), 64'({16'd9, 16'd11}));
         check("bp_no_grant", 64'(req0_ready), 64'(0));
         @(posedge clk); #1;
      end
      mult_in_ready = 1'b1;
      req0_valid = 1'b0;
      @(negedge clk);
      check("bp_release_valid", 64'(mult_in_valid), 64'(1));
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_issued_valid", 64'(mult_in_valid), 64'(0));
      check("bp_outstanding", 64'(outstanding), 64'(1));
      @(posedge clk); #1;
      return_result(32'd99, 1'b0);
      @(negedge clk);
      check("bp_rsp0", 64'({rsp0_valid, rsp0_result}), 64'({1'b1, 32'd99}));
      @(posedge clk); #1;

      // Full: requester 0 always valid, no results returned.
      set_req0(1'b1, 16'd1, 16'd1);
      grants = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (req0_ready) grants++;
         check("full_outstanding_max", 64'(outstanding <= TD), 64'(1));
         @(posedge clk); #1;
      end
      check("full_grant_count", 64'(grants), 64'(TD));
      check("full_outstanding", 64'(outstanding), 64'(TD));
      mult_out_valid = 1'b1; mult_result = 32'd1; mult_result_parity = 1'b1;
      @(negedge clk);
      check("full_no_grant_on_pop", 64'(req0_ready), 64'(0));
      @(posedge clk); #1;
      mult_out_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 6 && !found; k++) begin
         @(negedge clk);
         if (req0_ready) found = 1'b1;
         @(posedge clk); #1;
      end
      req0_valid = 1'b0;
      check("full_regrant", 64'(found), 64'(1));
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("full_refilled", 64'(outstanding), 64'(TD));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("full_reset_outstanding", 64'(outstanding), 64'(0));
      @(posedge clk); #1;

      // Parity error on requester 1 passes straight through and is routed back.
      req1_valid = 1'b1; req1_arg_a = 16'd1; req1_arg_a_parity = 1'b0;
      req1_arg_b = 16'd1; req1_arg_b_parity = 1'b1;
      @(negedge clk);
      check("perr_grant", 64'(req1_ready), 64'(1));
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(negedge clk);
      check("perr_parity_passthru", 64'({mult_in_valid, mult_arg_a_parity, mult_arg_b_parity}),
            64'(3'b101));
      @(posedge clk); #1;
      return_result(32'd1, 1'b1);
      @(negedge clk);
      check("perr_rsp1", 64'({rsp1_valid, rsp1_result_parity, rsp1_parity_error, rsp0_valid}),
            64'(4'b1110));
      @(posedge clk); #1;

      // Spurious result with nothing outstanding.
      mult_out_valid = 1'b1; mult_result = 32'h55;
      @(negedge clk);
      check("spur_before", 64'(err_spurious), 64'(0));
      @(posedge clk); #1;
      mult_out_valid = 1'b0;
      @(negedge clk);
      check("spur_set", 64'(err_spurious), 64'(1));
      check("spur_no_rsp", 64'({rsp0_valid, rsp1_valid}), 64'(0));
      check("spur_outstanding", 64'(outstanding), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("spur_sticky", 64'(err_spurious), 64'(1));
      @(posedge clk); #1;

      // Reset with two operations in flight.
      set_req0(1'b1, 16'd5, 16'd6);
      grants = 0;
      for (int k = 0; k < 10 && grants < 2; k++) begin
         @(negedge clk);
         if (req0_ready) grants++;
         @(posedge clk); #1;
      end
      req0_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst2_outstanding", 64'(outstanding), 64'(2));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_zero("rst2");
      @(posedge clk); #1;

      // Random traffic against a queue model; the last 80 cycles drain everything.
      issued = 0; returned = 0; prev_rv = 1'b0; exp_next = 1'b0;
      prev = '{1'b0, 32'd0, 1'b0, 1'b0};
      for (int cyc = 0; cyc < 480; cyc++) begin
         logic drain;
         drain = (cyc >= 400);
         req0_valid = drain ? 1'b0 : 1'($urandom_range(0, 1));
         req0_arg_a = 16'($urandom); req0_arg_b = 16'($urandom);
         req0_arg_a_parity = (^req0_arg_a) ^ ($urandom_range(0, 7) == 0);
         req0_arg_b_parity = (^req0_arg_b) ^ ($urandom_range(0, 7) == 0);
         req1_valid = drain ? 1'b0 : 1'($urandom_range(0, 1));
         req1_arg_a = 16'($urandom); req1_arg_b = 16'($urandom);
         req1_arg_a_parity = (^req1_arg_a) ^ ($urandom_range(0, 7) == 0);
         req1_arg_b_parity = (^req1_arg_b) ^ ($urandom_range(0, 7) == 0);
         mult_in_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
         mult_out_valid = 1'b0; mult_result = '0;
         mult_result_parity = 1'b0; mult_arg_parity_error = 1'b0;
         cur_rv = 1'b0;
         cur = prev;
         if (mq.size() > 0 && (drain || $urandom_range(0, 2) == 0)) begin
            res_t m;
            m = mq.pop_front();
            mult_out_valid = 1'b1; mult_result = m.prod;
            mult_result_parity = m.rpar; mult_arg_parity_error = m.perr;
            cur_rv = 1'b1;
            cur = accq.pop_front();
         end
         @(negedge clk);
         check("rand_rsp0_valid", 64'(rsp0_valid), 64'(prev_rv & ~prev.id));
         check("rand_rsp1_valid", 64'(rsp1_valid), 64'(prev_rv & prev.id));
         if (prev_rv) begin
            check("rand_rsp_data",
                  64'(prev.id ? {rsp1_result, rsp1_result_parity, rsp1_parity_error}
                              : {rsp0_result, rsp0_result_parity, rsp0_parity_error}),
                  64'({prev.prod, prev.rpar, prev.perr}));
         end
         check("rand_outstanding", 64'(outstanding), 64'(issued - returned));
         check("rand_ready_legal", 64'((req0_ready & (req1_ready | ~req0_valid)) |
                                       (req1_ready & ~req1_valid)), 64'(0));
         if (req0_valid && req1_valid && (req0_ready || req1_ready)) begin
            check("rand_rr_winner", 64'(req1_ready), 64'(exp_next));
            exp_next = ~exp_next;
         end
         if (req0_ready) accq.push_back(mk_res(1'b0, req0_arg_a, req0_arg_b,
                                               req0_arg_a_parity, req0_arg_b_parity));
         if (req1_ready) accq.push_back(mk_res(1'b1, req1_arg_a, req1_arg_b,
                                               req1_arg_a_parity, req1_arg_b_parity));
         if (mult_in_valid && mult_in_ready) begin
            mq.push_back(mk_res(1'b0, mult_arg_a, mult_arg_b, mult_arg_a_parity,
                                mult_arg_b_parity));
            issued++;
         end
         if (cur_rv) returned++;
         prev = cur;
         prev_rv = cur_rv;
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("rand_drained_queues", 64'(accq.size() + mq.size()), 64'(0));
      check("rand_drained_outstanding", 64'(outstanding), 64'(0));
      check("rand_no_spurious", 64'(err_spurious), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
